hqm_reorder_pipe_flr_prep_ctl: RTL and testbench

Sequencer for function-level-reset (FLR) preparation of the reorder pipe output interfaces. On an FLR request it does three things in order: asks upstream to stop issuing work, waits for all protected interfaces to go quiet (or for a drain timeout), then asserts `flr_prep` to the per-interface protection cells. The seven protected interfaces are alarm_down, cfg_req_down read/write, dp_enq, lsp_reordercmp, nalb_enq and qed_dqed_enq. The block sits between the FLR control logic and those protection cells, and holds protection until the request is withdrawn.

---
 rtl/hqm_reorder_pipe_flr_prep_ctl.sv | 134 +++++++++++++
 tb/tb_hqm_reorder_pipe_flr_prep_ctl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hqm_reorder_pipe_flr_prep_ctl.sv
// rtl/hqm_reorder_pipe_flr_prep_ctl.sv - FLR preparation sequencer for the reorder pipe output interfaces
module hqm_reorder_pipe_flr_prep_ctl #(
    parameter int NUM_IF       = 7,
    parameter int QUIET_CYCLES = 4,
    parameter int TIMEOUT_W    = 16
) (
    input  logic                 hqm_gated_clk,
    input  logic                 hqm_gated_rst_n,
    input  logic                 flr_req,
    input  logic [NUM_IF-1:0]    if_v,
    input  logic [NUM_IF-1:0]    if_busy,
    input  logic [TIMEOUT_W-1:0] cfg_drain_timeout,
    output logic                 rop_stop,
    output logic                 flr_prep,
    output logic                 flr_prep_done,
    output logic                 drain_timeout_alarm,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_PROT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [4:0]           QUIET_TARGET = 5'(QUIET_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TMO_ONE      = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] TMO_MAX      = {TIMEOUT_W{1'b1}};

    state_t                 state;
    state_t                 state_next;
    logic [3:0]             quiet_cnt;
    logic [TIMEOUT_W-1:0]   tmo_cnt;

    logic                   quiet;
    logic                   quiet_done;
    logic                   tmo_hit;
    logic                   alarm_next;

    // Qualify drain completion: quiet window full, or timeout with quiet taking precedence
    always_comb begin
        quiet      = ((if_v | if_busy) == '0);
        quiet_done = 1'b0;
        tmo_hit    = 1'b0;
        if (state == ST_DRAIN) begin
            quiet_done = quiet && (({1'b0, quiet_cnt} + 5'd1) == QUIET_TARGET);
            tmo_hit    = (cfg_drain_timeout != '0) &&
                         (tmo_cnt == (cfg_drain_timeout - TMO_ONE)) &&
                         !quiet_done;
        end
    end

    // Next-state decode; withdrawing the request in DRAIN aborts ahead of any completion
    always_comb begin
        state_next = state;
        alarm_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flr_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!flr_req) begin
                    state_next = ST_IDLE;
                end else if (quiet_done) begin
                    state_next = ST_PROT;
                end else if (tmo_hit) begin
                    state_next = ST_PROT;
                    alarm_next = 1'b1;
                end
            end
            ST_PROT: begin
                if (!flr_req) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge hqm_gated_clk) begin
        if (!hqm_gated_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Quiet-window and timeout counters live only while remaining in DRAIN
    always_ff @(posedge hqm_gated_clk) begin
        if (!hqm_gated_rst_n) begin
            quiet_cnt <= 4'd0;
            tmo_cnt   <= '0;
        end else if ((state == ST_DRAIN) && (state_next == ST_DRAIN)) begin
            if (!quiet) begin
                quiet_cnt <= 4'd0;
            end else if (quiet_cnt != 4'hF) begin
                quiet_cnt <= quiet_cnt + 4'd1;
            end
            if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + TMO_ONE;
            end
        end else begin
            quiet_cnt <= 4'd0;
            tmo_cnt   <= '0;
        end
    end

    // Outputs decoded from the next state so they move on the same edge as the state
    always_ff @(posedge hqm_gated_clk) begin
        if (!hqm_gated_rst_n) begin
            rop_stop            <= 1'b0;
            flr_prep            <= 1'b0;
            flr_prep_done       <= 1'b0;
            drain_timeout_alarm <= 1'b0;
        end else begin
            rop_stop            <= (state_next != ST_IDLE);
            flr_prep            <= (state_next == ST_PROT);
            flr_prep_done       <= (state_next == ST_PROT);
            drain_timeout_alarm <= alarm_next;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_hqm_reorder_pipe_flr_prep_ctl.sv
// tb/tb_hqm_reorder_pipe_flr_prep_ctl.sv - directed scoreboard bench for the FLR preparation sequencer
module tb_hqm_reorder_pipe_flr_prep_ctl;

    localparam int NUM_IF    = 7;
    localparam int TIMEOUT_W = 16;

    // Expected output vector: {fsm_state[1:0], rop_stop, flr_prep, flr_prep_done, drain_timeout_alarm}
    localparam logic [5:0] E_IDLE  = {2'd0, 4'b0000};
    localparam logic [5:0] E_DRAIN = {2'd1, 4'b1000};
    localparam logic [5:0] E_PROT  = {2'd2, 4'b1110};
    localparam logic [5:0] E_ALARM = {2'd2, 4'b1111};
    localparam logic [5:0] E_REL   = {2'd3, 4'b1000};

    logic                 clk;
    logic                 rst_n;
    logic                 flr_req;
    logic [NUM_IF-1:0]    if_v;
    logic [NUM_IF-1:0]    if_busy;
    logic [TIMEOUT_W-1:0] cfg_drain_timeout;
    logic                 rop_stop;
    logic                 flr_prep;
    logic                 flr_prep_done;
    logic                 drain_timeout_alarm;
    logic [1:0]           fsm_state;

    int checks;
    int errors;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    hqm_reorder_pipe_flr_prep_ctl #(
        .NUM_IF       (NUM_IF),
        .QUIET_CYCLES (4),
        .TIMEOUT_W    (TIMEOUT_W)
    ) dut (
        .hqm_gated_clk       (clk),
        .hqm_gated_rst_n     (rst_n),
        .flr_req             (flr_req),
        .if_v                (if_v),
        .if_busy             (if_busy),
        .cfg_drain_timeout   (cfg_drain_timeout),
        .rop_stop            (rop_stop),
        .flr_prep            (flr_prep),
        .flr_prep_done       (flr_prep_done),
        .drain_timeout_alarm (drain_timeout_alarm),
        .fsm_state           (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, push the expectation for the cycle after the edge, then pop and compare
    task automatic step(input logic req, input logic [NUM_IF-1:0] v, input logic [NUM_IF-1:0] b,
                        input logic [5:0] exp, input string tag);
        logic [5:0] obs;
        logic [5:0] want;
        string      t;
        @(negedge clk);
        flr_req = req;
        if_v    = v;
        if_busy = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        obs  = {fsm_state, rop_stop, flr_prep, flr_prep_done, drain_timeout_alarm};
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed {state,rop,prep,done,alarm}=%b_%b required %b_%b",
                   t, obs[5:4], obs[3:0], want[5:4], want[3:0]);
        end
    endtask

    task automatic run(input int n, input logic req, input logic [NUM_IF-1:0] v,
                       input logic [NUM_IF-1:0] b, input logic [5:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            step(req, v, b, exp, tag);
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst_n             = 1'b0;
        flr_req           = 1'b0;
        if_v              = '0;
        if_busy           = '0;
        cfg_drain_timeout = '0;

        // Reset holds everything at zero even with a request pending
        run(2, 1'b0, '0, '0, E_IDLE, "reset_idle");
        run(1, 1'b1, '0, '0, E_IDLE, "reset_with_req");
        rst_n = 1'b1;
        run(3, 1'b0, 7'h7F, 7'h7F, E_IDLE, "idle_hold");

        // Clean drain: req sampled at T, DRAIN T+1..T+4, PROT from T+5
        step(1'b1, '0, '0, E_DRAIN, "clean_enter_drain");
        run(3, 1'b1, '0, '0, E_DRAIN, "clean_drain");
        step(1'b1, '0, '0, E_PROT, "clean_prot_rise");
        run(3, 1'b1, 7'h7F, 7'h7F, E_PROT, "prot_ignores_if");
        step(1'b0, '0, '0, E_REL, "release_settle");
        step(1'b0, '0, '0, E_IDLE, "release_idle");
        run(2, 1'b0, '0, '0, E_IDLE, "post_release_idle");

        // Glitch on if_busy[3] at T+3 restarts the quiet window: PROT from T+8
        step(1'b1, '0, '0, E_DRAIN, "glitch_enter");
        run(2, 1'b1, '0, '0, E_DRAIN, "glitch_pre");
        step(1'b1, '0, 7'b0001000, E_DRAIN, "glitch_busy");
        run(3, 1'b1, '0, '0, E_DRAIN, "glitch_requiet");
        step(1'b1, '0, '0, E_PROT, "glitch_prot_no_alarm");
        step(1'b0, '0, '0, E_REL, "glitch_release");
        step(1'b0, '0, '0, E_IDLE, "glitch_idle");

        // Timeout N=20 with if_v[0] stuck: PROT plus one-cycle alarm from T+21
        cfg_drain_timeout = 16'd20;
        step(1'b1, 7'b0000001, '0, E_DRAIN, "tmo_enter");
        run(19, 1'b1, 7'b0000001, '0, E_DRAIN, "tmo_drain");
        step(1'b1, 7'b0000001, '0, E_ALARM, "tmo_alarm");
        run(2, 1'b1, 7'b0000001, '0, E_PROT, "tmo_alarm_single");
        step(1'b0, '0, '0, E_REL, "tmo_release");
        step(1'b0, '0, '0, E_IDLE, "tmo_idle");

        // Quiet completion coincides with timeout N=4: quiet wins, no alarm
        cfg_drain_timeout = 16'd4;
        step(1'b1, '0, '0, E_DRAIN, "coinc_enter");
        run(3, 1'b1, '0, '0, E_DRAIN, "coinc_drain");
        step(1'b1, '0, '0, E_PROT, "coinc_prot_no_alarm");
        step(1'b1, '0, '0, E_PROT, "coinc_hold");
        step(1'b0, '0, '0, E_REL, "coinc_release");
        step(1'b0, '0, '0, E_IDLE, "coinc_idle");

        // Abort from DRAIN: straight back to IDLE, protection never raised
        cfg_drain_timeout = '0;
        step(1'b1, 7'b0100000, '0, E_DRAIN, "abort_enter");
        run(2, 1'b1, 7'b0100000, '0, E_DRAIN, "abort_drain");
        step(1'b0, 7'b0100000, '0, E_IDLE, "abort_idle");
        run(2, 1'b0, '0, '0, E_IDLE, "abort_stay_idle");

        // Timeout lowered below the elapsed count mid-DRAIN never fires
        step(1'b1, '0, 7'b1000000, E_DRAIN, "late_cfg_enter");
        run(9, 1'b1, '0, 7'b1000000, E_DRAIN, "late_cfg_drain");
        cfg_drain_timeout = 16'd5;
        run(6, 1'b1, '0, 7'b1000000, E_DRAIN, "late_cfg_no_fire");
        step(1'b0, '0, '0, E_IDLE, "late_cfg_abort");
        cfg_drain_timeout = '0;

        // Reset while protected, then a full fresh sequence
        step(1'b1, '0, '0, E_DRAIN, "rst_mid_enter");
        run(3, 1'b1, '0, '0, E_DRAIN, "rst_mid_drain");
        step(1'b1, '0, '0, E_PROT, "rst_mid_prot");
        rst_n = 1'b0;
        step(1'b1, '0, '0, E_IDLE, "rst_mid_prot_drop");
        rst_n = 1'b1;
        step(1'b1, '0, '0, E_DRAIN, "rerun_enter");
        run(3, 1'b1, '0, '0, E_DRAIN, "rerun_drain");
        step(1'b1, '0, '0, E_PROT, "rerun_prot");
        step(1'b0, '0, '0, E_REL, "rerun_release");
        step(1'b1, '0, '0, E_IDLE, "release_ignores_req");
        step(1'b1, '0, '0, E_DRAIN, "fresh_drain_after_release");
        step(1'b0, '0, '0, E_IDLE, "final_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
